// File: rtl/output_word_sequencer.sv
// output_word_sequencer: steps a registered one-hot word select across a wrapping index range with valid/ready readout
module output_word_sequencer #(
    parameter int N_WORDS = 16,
    parameter int IDX_W   = $clog2(N_WORDS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [IDX_W-1:0]   first_i,
    input  logic [IDX_W-1:0]   last_i,
    input  logic               abort_i,
    input  logic               ready_i,
    output logic [N_WORDS-1:0] word_select_o,
    output logic [IDX_W-1:0]   word_idx_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;
    localparam logic [N_WORDS-1:0] ONE = N_WORDS'(1);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(N_WORDS - 1);

    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_last;
    logic [N_WORDS-1:0] r_sel;
    logic               r_done;
    logic               r_err;
    logic               w_bad;
    logic [IDX_W-1:0]   w_next;

    // Out-of-range indices only exist when N_WORDS leaves part of the index space unused
    generate
        if (N_WORDS == (1 << IDX_W)) begin : g_pow2
            assign w_bad = 1'b0;
        end else begin : g_range
            assign w_bad = (first_i >= IDX_W'(N_WORDS)) || (last_i >= IDX_W'(N_WORDS));
        end
    endgenerate

    // Successor index wraps from the top word back to word 0
    always_comb begin
        w_next = (r_idx == TOP) ? '0 : r_idx + 1'b1;
    end

    // Scan state, index and select registers; abort outranks a transfer, even on the last word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_sel   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == IDLE) begin
                if (start_i && w_bad) begin
                    r_err <= 1'b1;
                end else if (start_i) begin
                    r_state <= SCAN;
                    r_idx   <= first_i;
                    r_last  <= last_i;
                    r_sel   <= ONE << first_i;
                end
            end else if (abort_i) begin
                r_state <= IDLE;
                r_sel   <= '0;
            end else if (ready_i && r_idx == r_last) begin
                r_state <= IDLE;
                r_sel   <= '0;
                r_done  <= 1'b1;
            end else if (ready_i) begin
                r_idx <= w_next;
                r_sel <= ONE << w_next;
            end
        end
    end

    assign word_select_o = r_sel;
    assign word_idx_o    = r_idx;
    assign busy_o        = (r_state == SCAN);
    assign valid_o       = (r_state == SCAN);
    assign done_o        = r_done;
    assign err_o         = r_err;
endmodule

// File: tb/tb_output_word_sequencer.sv
// tb_output_word_sequencer: scoreboard bench for the 16-word and 10-word sequencer builds
module tb_output_word_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, ready;
    logic [3:0]  first, last;
    logic [15:0] sel;
    logic [3:0]  idx;
    logic        valid, busy, done, err;

    logic        start_b, abort_b, ready_b;
    logic [3:0]  first_b, last_b;
    logic [9:0]  sel_b;
    logic [3:0]  idx_b;
    logic        valid_b, busy_b, done_b, err_b;

    int n_pass = 0;
    int n_total = 0;
    logic [3:0] q[$];

    output_word_sequencer #(.N_WORDS(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .first_i(first), .last_i(last),
        .abort_i(abort), .ready_i(ready), .word_select_o(sel), .word_idx_o(idx),
        .valid_o(valid), .busy_o(busy), .done_o(done), .err_o(err)
    );

    output_word_sequencer #(.N_WORDS(10)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .first_i(first_b), .last_i(last_b),
        .abort_i(abort_b), .ready_i(ready_b), .word_select_o(sel_b), .word_idx_o(idx_b),
        .valid_o(valid_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
        n_total++;
        if ({sel, idx, valid, busy, done, err} !== 24'd0)
            $display("FAIL reset16 got %h want 0", {sel, idx, valid, busy, done, err});
        else n_pass++;
        n_total++;
        if ({sel_b, idx_b, valid_b, busy_b, done_b, err_b} !== 18'd0)
            $display("FAIL reset10 got %h want 0", {sel_b, idx_b, valid_b, busy_b, done_b, err_b});
        else n_pass++;
    endtask

    task automatic test_scan(input string name, input logic [3:0] f, input logic [3:0] l,
                             input int stall_idx, input int stall_n);
        int w, vcount, stalls, k;
        w = ((int'(l) - int'(f) + 16) % 16) + 1;
        for (int i = 0; i < w; i++) q.push_back(4'((int'(f) + i) % 16));
        vcount = 0;
        stalls = stall_n;
        first = f;
        last = l;
        start = 1'b1;
        ready = 1'b1;
        for (k = 0; k < 200 && q.size() > 0; k++) begin
            step;
            start = 1'b0;
            n_total++;
            if (valid !== 1'b1 || busy !== 1'b1) begin
                $display("FAIL %s valid/busy got %b%b want 11 with %0d words pending", name, valid, busy, q.size());
                q.delete();
                break;
            end else n_pass++;
            vcount++;
            n_total++;
            if (idx !== q[0] || sel !== (16'd1 << q[0]))
                $display("FAIL %s word got idx %0d sel %h want idx %0d sel %h", name, idx, sel, q[0], 16'd1 << q[0]);
            else n_pass++;
            if (int'(idx) == stall_idx && stalls > 0) begin
                ready = 1'b0;
                stalls--;
            end else begin
                ready = 1'b1;
                void'(q.pop_front());
            end
        end
        if (k >= 200) begin
            n_total++;
            $display("FAIL %s timeout with %0d words pending", name, q.size());
            q.delete();
        end
        step;
        n_total++;
        if ({done, busy, valid, sel} !== {1'b1, 1'b0, 1'b0, 16'd0})
            $display("FAIL %s end got done %b busy %b valid %b sel %h want 1 0 0 0000", name, done, busy, valid, sel);
        else n_pass++;
        n_total++;
        if (vcount !== w + stall_n)
            $display("FAIL %s valid cycles got %0d want %0d", name, vcount, w + stall_n);
        else n_pass++;
        step;
        n_total++;
        if (done !== 1'b0) $display("FAIL %s done width got %b want 0", name, done);
        else n_pass++;
    endtask

    task automatic test_abort_last;
        first = 4'd2;
        last = 4'd3;
        start = 1'b1;
        ready = 1'b1;
        step;
        start = 1'b0;
        step;
        n_total++;
        if (idx !== 4'd3 || valid !== 1'b1) $display("FAIL abort_pre got idx %0d valid %b want 3 1", idx, valid);
        else n_pass++;
        abort = 1'b1;
        step;
        abort = 1'b0;
        n_total++;
        if ({done, busy, valid, sel} !== 19'd0)
            $display("FAIL abort_last got done %b busy %b valid %b sel %h want all 0", done, busy, valid, sel);
        else n_pass++;
        step;
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_after got done %b busy %b want 0 0", done, busy);
        else n_pass++;
    endtask

    task automatic test_start_ignored;
        first = 4'd6;
        last = 4'd7;
        start = 1'b1;
        ready = 1'b1;
        step;
        first = 4'd0;
        last = 4'd0;
        n_total++;
        if (idx !== 4'd6 || busy !== 1'b1) $display("FAIL ign_first got idx %0d busy %b want 6 1", idx, busy);
        else n_pass++;
        step;
        n_total++;
        if (idx !== 4'd7 || sel !== 16'h0080 || err !== 1'b0)
            $display("FAIL ign_scan got idx %0d sel %h err %b want 7 0080 0", idx, sel, err);
        else n_pass++;
        step;
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL ign_done got done %b busy %b want 1 0", done, busy);
        else n_pass++;
        step;
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1 || idx !== 4'd0 || sel !== 16'h0001)
            $display("FAIL restart_on_done got busy %b idx %0d sel %h want 1 0 0001", busy, idx, sel);
        else n_pass++;
        step;
        n_total++;
        if (done !== 1'b1 || sel !== 16'd0) $display("FAIL restart_end got done %b sel %h want 1 0000", done, sel);
        else n_pass++;
        step;
    endtask

    task automatic test_err;
        ready_b = 1'b1;
        first_b = 4'd12;
        last_b = 4'd0;
        start_b = 1'b1;
        step;
        start_b = 1'b0;
        n_total++;
        if (err_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL err_first got err %b busy %b want 1 0", err_b, busy_b);
        else n_pass++;
        step;
        n_total++;
        if (err_b !== 1'b0 || busy_b !== 1'b0) $display("FAIL err_pulse got err %b busy %b want 0 0", err_b, busy_b);
        else n_pass++;
        first_b = 4'd0;
        last_b = 4'd10;
        start_b = 1'b1;
        step;
        start_b = 1'b0;
        n_total++;
        if (err_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL err_last got err %b busy %b want 1 0", err_b, busy_b);
        else n_pass++;
        q.push_back(4'd9);
        q.push_back(4'd0);
        first_b = 4'd9;
        last_b = 4'd0;
        start_b = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step;
            start_b = 1'b0;
            n_total++;
            if (valid_b !== 1'b1 || idx_b !== q[0] || sel_b !== (10'd1 << q[0]))
                $display("FAIL wrap10 got valid %b idx %0d sel %h want 1 %0d %h", valid_b, idx_b, sel_b, q[0], 10'd1 << q[0]);
            else n_pass++;
            void'(q.pop_front());
        end
        step;
        n_total++;
        if (done_b !== 1'b1 || sel_b !== 10'd0 || err_b !== 1'b0)
            $display("FAIL wrap10_end got done %b sel %h err %b want 1 000 0", done_b, sel_b, err_b);
        else n_pass++;
    endtask

    task automatic test_rst_mid;
        int k;
        first = 4'd4;
        last = 4'd10;
        start = 1'b1;
        ready = 1'b1;
        for (k = 0; k < 20; k++) begin
            step;
            start = 1'b0;
            if (idx == 4'd7 && valid) break;
        end
        n_total++;
        if (k >= 20) $display("FAIL rst_mid_reach timeout got idx %0d want 7", idx);
        else n_pass++;
        rst = 1'b1;
        step;
        rst = 1'b0;
        n_total++;
        if ({sel, idx, valid, busy, done, err} !== 24'd0)
            $display("FAIL rst_mid got %h want 0", {sel, idx, valid, busy, done, err});
        else n_pass++;
        step;
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_after got done %b busy %b want 0 0", done, busy);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        {start, abort, ready, first, last} = '0;
        {start_b, abort_b, ready_b, first_b, last_b} = '0;
        test_reset;
        test_scan("full", 4'd0, 4'd15, -1, 0);
        test_scan("wrap", 4'd14, 4'd1, -1, 0);
        test_scan("backpressure", 4'd3, 4'd5, 4, 3);
        test_abort_last;
        test_start_ignored;
        test_err;
        test_rst_mid;
        test_scan("single", 4'd5, 4'd5, -1, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
